// File: rtl/fp_wire.sv
// ============================================================================
// fp_wire : shared types and constants for the fpu.dat trace writer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package fp_wire;

  localparam int REC_W = 288;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_OVF    = 2'd1;
  localparam logic [1:0] ERR_ORPHAN = 2'd2;

  typedef struct packed {
    logic [63:0] data1;
    logic [63:0] data2;
    logic [63:0] data3;
    logic [63:0] result;
    logic [2:0]  pad_31_29;
    logic [4:0]  flags;
    logic [1:0]  pad_23_22;
    logic [1:0]  fmt;
    logic        pad_19;
    logic [2:0]  rm;
    logic [1:0]  pad_15_14;
    logic [1:0]  cvt_op;
    logic [1:0]  pad_11_10;
    logic [9:0]  opcode;
  } fp_trace_rec;

  // One in-flight issue; keep=0 entries exist only to stay aligned with fp_unit.
  typedef struct packed {
    logic        keep;
    logic [63:0] data1;
    logic [63:0] data2;
    logic [63:0] data3;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [1:0]  cvt_op;
    logic [9:0]  opcode;
  } fp_pend_entry;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fp_trace_state_e;

endpackage

`default_nettype wire

// File: rtl/fp_trace_packer_if.sv
// ============================================================================
// fp_trace_packer_if : issue/result snoop and record stream bundle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface fp_trace_packer_if;
  import fp_wire::*;

  logic              trace_en;
  logic              iss_valid;
  logic [63:0]       iss_data1;
  logic [63:0]       iss_data2;
  logic [63:0]       iss_data3;
  logic [1:0]        iss_fmt;
  logic [2:0]        iss_rm;
  logic [1:0]        iss_cvt_op;
  logic [9:0]        iss_opcode;
  logic              res_ready;
  logic [63:0]       res_result;
  logic [4:0]        res_flags;
  logic              rec_valid;
  logic [REC_W-1:0]  rec_data;
  logic              rec_ready;

  modport master (
    output trace_en, iss_valid, iss_data1, iss_data2, iss_data3,
           iss_fmt, iss_rm, iss_cvt_op, iss_opcode,
           res_ready, res_result, res_flags, rec_ready,
    input  rec_valid, rec_data
  );

  modport slave (
    input  trace_en, iss_valid, iss_data1, iss_data2, iss_data3,
           iss_fmt, iss_rm, iss_cvt_op, iss_opcode,
           res_ready, res_result, res_flags, rec_ready,
    output rec_valid, rec_data
  );

endinterface

`default_nettype wire

// File: rtl/fp_trace_fifo.sv
// ============================================================================
// fp_trace_fifo : synchronous FIFO with wrap-bit pointers, combinational head
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fp_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [WIDTH-1:0] din,
  output logic                  full,
  output logic                  empty,
  output logic [WIDTH-1:0]      head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  always_ff @(posedge clock) begin
    if (push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/fp_trace_packer.sv
// ============================================================================
// fp_trace_packer : pairs fp_unit issues with in-order results into records
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fp_trace_packer
  import fp_wire::*;
#(
  parameter int PEND_DEPTH = 8,
  parameter int OUT_DEPTH  = 4,
  parameter int CNT_W      = 16
) (
  input  wire logic        clock,
  input  wire logic        reset,
  fp_trace_packer_if.slave trace,
  output logic [CNT_W-1:0] drop_count,
  output logic             halted,
  output logic [1:0]       err_code
);

  localparam int PEND_W = $bits(fp_pend_entry);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fp_trace_state_e r_state;
  fp_trace_state_e w_state_next;
  logic [1:0]      r_err_code;
  logic [1:0]      w_err_next;
  logic [CNT_W-1:0] r_drop_count;

  fp_pend_entry w_pend_din;
  fp_pend_entry w_pend_head;
  fp_trace_rec  w_rec;
  logic [REC_W-1:0] w_out_head;
  logic w_pend_full, w_pend_empty, w_out_full, w_out_empty;
  logic w_run, w_pend_push, w_pend_pop, w_out_push, w_out_pop, w_out_req;
  logic w_ovf, w_orphan, w_drop;

  assign w_run = (r_state == ST_RUN);

  // A same-cycle pop frees a slot in either FIFO, so push/pop are judged together.
  assign w_pend_pop  = w_run && trace.res_ready && !w_pend_empty;
  assign w_pend_push = w_run && trace.iss_valid && (!w_pend_full || w_pend_pop);
  assign w_ovf       = w_run && trace.iss_valid && w_pend_full && !w_pend_pop;
  assign w_orphan    = w_run && trace.res_ready && w_pend_empty;

  assign w_out_pop   = !w_out_empty && trace.rec_ready;
  assign w_out_req   = w_pend_pop && w_pend_head.keep;
  assign w_out_push  = w_out_req && (!w_out_full || w_out_pop);
  assign w_drop      = w_out_req && w_out_full && !w_out_pop;

  always_comb begin
    w_pend_din        = '0;
    w_pend_din.keep   = trace.trace_en;
    w_pend_din.data1  = trace.iss_data1;
    w_pend_din.data2  = trace.iss_data2;
    w_pend_din.data3  = trace.iss_data3;
    w_pend_din.fmt    = trace.iss_fmt;
    w_pend_din.rm     = trace.iss_rm;
    w_pend_din.cvt_op = trace.iss_cvt_op;
    w_pend_din.opcode = trace.iss_opcode;
  end

  always_comb begin
    w_rec        = '0;
    w_rec.data1  = w_pend_head.data1;
    w_rec.data2  = w_pend_head.data2;
    w_rec.data3  = w_pend_head.data3;
    w_rec.result = trace.res_result;
    w_rec.flags  = trace.res_flags;
    w_rec.fmt    = w_pend_head.fmt;
    w_rec.rm     = w_pend_head.rm;
    w_rec.cvt_op = w_pend_head.cvt_op;
    w_rec.opcode = w_pend_head.opcode;
  end

  fp_trace_fifo #(
    .WIDTH (PEND_W),
    .DEPTH (PEND_DEPTH)
  ) u_pend_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_pend_push),
    .pop   (w_pend_pop),
    .din   (w_pend_din),
    .full  (w_pend_full),
    .empty (w_pend_empty),
    .head  (w_pend_head)
  );

  fp_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_out_push),
    .pop   (w_out_pop),
    .din   (w_rec),
    .full  (w_out_full),
    .empty (w_out_empty),
    .head  (w_out_head)
  );

  // Orphan takes precedence when both errors hit together.
  always_comb begin
    w_state_next = r_state;
    w_err_next   = r_err_code;
    if (r_state == ST_RUN) begin
      if (w_orphan) begin
        w_state_next = ST_HALT;
        w_err_next   = ERR_ORPHAN;
      end else if (w_ovf) begin
        w_state_next = ST_HALT;
        w_err_next   = ERR_OVF;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_err_code <= ERR_NONE;
    end else begin
      r_state    <= w_state_next;
      r_err_code <= w_err_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != '1)) begin
      r_drop_count <= r_drop_count + CNT_ONE;
    end
  end

  assign trace.rec_valid = !w_out_empty;
  assign trace.rec_data  = w_out_empty ? '0 : w_out_head;
  assign drop_count      = r_drop_count;
  assign halted          = (r_state == ST_HALT);
  assign err_code        = r_err_code;

endmodule

`default_nettype wire
